bm_input_stage: RTL and testbench
=================================

# bm_input_stage

Master-side input stage of the custom AHB bus matrix, one instance per master port. It captures the master's address phase whenever the downstream output-stage arbiter cannot accept it in the same cycle. It then holds that transfer and raises a request towards the arbiters until granted, stalling the master with HREADYOUTS low meanwhile. It is the requester end of the round-robin arbitration: its request feeds an arbiter `req_portN`, and it observes that arbiter's grant and data-phase results.

## Interface
Parameters:
- ADDR_W, 32, address width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - HCLK  in  1  AHB system clock.
  - HRESETn  in  1  asynchronous active-low reset.
- Master-side inputs:
  - HSELS  in  1  master selects this bus matrix.
  - HADDRS  in  ADDR_W  address.
  - HTRANSS  in  2  transfer type.
  - HWRITES  in  1  write flag.
  - HSIZES  in  3  transfer size.
  - HBURSTS  in  3  burst type.
  - HPROTS  in  4  protection.
  - HMASTLOCKS  in  1  locked transfer.
  - HREADYS  in  1  bus-wide HREADY as seen by the master.
- Master-side outputs:
  - HREADYOUTS  out  1  ready returned to the master.
  - HRESPS  out  1  response returned to the master (0 OKAY, 1 ERROR).
- Towards decoder and output stages:
  - HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI  out  (as above)  muxed address-phase attributes.
  - trans_req_o  out  1  transfer request to arbiters.
  - addr_accept_i  in  1  granted output stage accepts the presented address this cycle (grant and slave HREADYM both high).
  - readyout_i  in  1  data-phase HREADYOUT from the selected slave path.
  - resp_i  in  1  data-phase HRESP from the selected slave path.

## Operation
- Capture condition `cap` = HSELS & HTRANSS[1] & HREADYS. Only NONSEQ and SEQ are captured; IDLE and BUSY are never held.
- FSM states:
  - IDLE: no held transfer, no data phase.
  - PEND: holding a transfer, waiting for grant.
  - DATA: accepted transfer in its data phase.
- Transitions:
  - IDLE:
    - cap & addr_accept_i -> DATA.
    - cap & ~addr_accept_i -> PEND, attributes latched.
    - otherwise stay in IDLE.
  - PEND:
    - addr_accept_i -> DATA.
    - Master inputs are ignored, since HREADYOUTS=0 keeps HREADYS low.
  - DATA:
    - readyout_i=0: stay in DATA.
    - readyout_i=1: evaluate cap exactly as in IDLE (back-to-back capture), otherwise -> IDLE.
- Outputs:
  - Address mux: PEND drives the holding register; other states drive the live master inputs.
  - trans_req_o = (state==PEND) | cap.
  - HREADYOUTS = PEND ? 0 : DATA ? readyout_i : 1.
  - HRESPS = DATA ? resp_i : 0.
- Holding register: loads only on a capture with ~addr_accept_i, and is otherwise unchanged.
- ERROR response: both ERROR cycles pass through. A transfer captured in the second ERROR cycle (readyout_i=1, resp_i=1) is handled normally. The master is responsible for driving IDLE there if it cancels.
- Locked sequences: HMASTLOCKI is muxed like the other attributes. Holding the lock is the arbiter's job.

## Timing
- Reset values:
  - State IDLE.
  - HREADYOUTS=1, HRESPS=0.
  - trans_req_o=0.
  - Holding register all zero; HTRANSI shows the live HTRANSS.
- Reset asserted mid-PEND or mid-DATA: the held transfer is discarded immediately, asynchronously, with no request after release.
- Latency:
  - Zero added cycles when the grant is present in the capture cycle.
  - Otherwise the master sees exactly N extra wait states, where N = cycles spent in PEND.
- A simultaneous addr_accept_i and capture in DATA with readyout_i=1 goes to DATA; the live attributes are used with no register load.
- addr_accept_i is ignored in IDLE without cap.

## Configuration
- Macro: BM_INPUT_SEQ_REMAP_EN.
- Defined:
  - A held SEQ transfer is presented from PEND as HTRANSI=NONSEQ and HBURSTI=INCR.
  - A remap flag then forces HBURSTI=INCR on the live SEQ beats that follow, until the master issues NONSEQ or IDLE, or HSELS drops.
  - This keeps the arbiter's burst counter from miscounting after a lost grant.
- Undefined: held attributes are presented unmodified; there is no remap flag.

## Structure
- Shared package `bm_pkg`:
  - HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
  - HBURST encodings (SINGLE 000 .. INCR16 111).
  - HRESP OKAY/ERROR.
  - FSM state enum.
- One sub-module, `bm_input_hold_reg`: address-phase holding register with load enable and the output mux. The FSM and remap logic stay in the top.

## Test plan
- Immediate grant: NONSEQ to 0x1000 with addr_accept_i=1 -> no PEND; HREADYOUTS follows readyout_i in the next cycle; HADDRI=0x1000 live.
- Delayed grant: NONSEQ write to 0x2004, addr_accept_i low for 3 cycles -> trans_req_o=1 and HREADYOUTS=0 for 3 cycles; HADDRI stays 0x2004 while HADDRS changes; then DATA.
- Back-to-back: DATA with readyout_i=1, next NONSEQ not accepted -> PEND with the new attributes latched; HRESPS=OKAY.
- Error: resp_i=1 for two cycles (readyout_i 0 then 1) -> HRESPS=1 both cycles, HREADYOUTS 0 then 1; master IDLE -> IDLE state.
- Remap (macro on): SEQ to 0x3008 with HBURSTS=INCR4 held -> HTRANSI=NONSEQ, HBURSTI=INCR; following SEQ beat HBURSTI=INCR. Macro off: SEQ and INCR4 unchanged.
- Reset in PEND: assert HRESETn=0 -> trans_req_o=0 and HREADYOUTS=1 asynchronously; after release, state is IDLE.

Source files
------------

// File: rtl/bm_pkg.sv
// Shared definitions for the AHB bus matrix: HTRANS/HBURST/HRESP encodings,
// the input-stage FSM state type and the address-phase attribute bundle.
package bm_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // IDLE: nothing held; PEND: holding a transfer awaiting grant;
    // DATA: accepted transfer in its data phase.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } bm_state_e;

    // Address-phase attributes other than the address itself.
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic       lock;
    } bm_attr_t;

    // NONSEQ and SEQ are the only transfer types that carry real work.
    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/bm_input_hold_reg.sv
// Address-phase holding register for one master port plus the mux that
// presents either the held transfer or the live master attributes.
module bm_input_hold_reg
    import bm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              load_i,
    input  logic              sel_hold_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  bm_attr_t          attr_i,
    output logic [ADDR_W-1:0] addr_o,
    output bm_attr_t          attr_o
);

    logic [ADDR_W-1:0] addr_d, addr_q;
    bm_attr_t          attr_d, attr_q;

    // Load a new transfer only when told to; otherwise keep the held one.
    always_comb begin
        addr_d = addr_q;
        attr_d = attr_q;
        if (load_i) begin
            addr_d = addr_i;
            attr_d = attr_i;
        end
    end

    // Holding register, cleared to all zero on reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q <= '0;
            attr_q <= '0;
        end else begin
            addr_q <= addr_d;
            attr_q <= attr_d;
        end
    end

    // Present the held transfer when selected, the live inputs otherwise.
    always_comb begin
        addr_o = sel_hold_i ? addr_q : addr_i;
        attr_o = sel_hold_i ? attr_q : attr_i;
    end

endmodule

// File: rtl/bm_input_stage.sv
// Master-side input stage of the AHB bus matrix. Holds an address phase the
// arbiter could not take immediately, requests until granted and stalls the
// master meanwhile. Optional feature macro: BM_INPUT_SEQ_REMAP_EN (present a
// held SEQ as NONSEQ/INCR and keep following live SEQ beats as INCR).
//
// Handshake: a transfer is offered whenever trans_req_o is high; it is taken
// in the cycle addr_accept_i is high, and the data phase completes in the
// cycle readyout_i is high. HREADYOUTS low means the master must hold.
module bm_input_stage
    import bm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic [ADDR_W-1:0] HADDRI,
    output logic [1:0]        HTRANSI,
    output logic              HWRITEI,
    output logic [2:0]        HSIZEI,
    output logic [2:0]        HBURSTI,
    output logic [3:0]        HPROTI,
    output logic              HMASTLOCKI,
    output logic              trans_req_o,
    input  logic              addr_accept_i,
    input  logic              readyout_i,
    input  logic              resp_i
);

    bm_state_e         state_d, state_q;
    logic              cap;
    logic              load;
    bm_attr_t          live_attr;
    bm_attr_t          mux_attr;
    bm_attr_t          out_attr;
    logic [ADDR_W-1:0] mux_addr;

    // Bundle the live master attributes for the holding register.
    always_comb begin
        live_attr.trans = HTRANSS;
        live_attr.write = HWRITES;
        live_attr.size  = HSIZES;
        live_attr.burst = HBURSTS;
        live_attr.prot  = HPROTS;
        live_attr.lock  = HMASTLOCKS;
    end

    // Next-state and hold-register load; DATA with readyout_i behaves as IDLE.
    always_comb begin
        cap     = HSELS & is_active(HTRANSS) & HREADYS;
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    state_d = addr_accept_i ? ST_DATA : ST_PEND;
                    load    = ~addr_accept_i;
                end
            end
            ST_PEND: begin
                if (addr_accept_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (readyout_i) begin
                    if (cap) begin
                        state_d = addr_accept_i ? ST_DATA : ST_PEND;
                        load    = ~addr_accept_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; reset discards any held transfer immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    bm_input_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load_i     (load),
        .sel_hold_i (state_q == ST_PEND),
        .addr_i     (HADDRS),
        .attr_i     (live_attr),
        .addr_o     (mux_addr),
        .attr_o     (mux_attr)
    );

`ifdef BM_INPUT_SEQ_REMAP_EN
    logic remap_d, remap_q;

    // Remap flag: set when a held SEQ is granted, cleared once the burst ends.
    always_comb begin
        remap_d = remap_q;
        if (remap_q && (!HSELS || HTRANSS == HTRANS_IDLE || HTRANSS == HTRANS_NONSEQ)) begin
            remap_d = 1'b0;
        end
        if (state_q == ST_PEND && addr_accept_i && mux_attr.trans == HTRANS_SEQ) begin
            remap_d = 1'b1;
        end
    end

    // Remap flag register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remap_q <= 1'b0;
        end else begin
            remap_q <= remap_d;
        end
    end

    // A held SEQ restarts as an undefined-length burst so the arbiter's
    // beat counting stays consistent after the lost grant.
    always_comb begin
        out_attr = mux_attr;
        if (state_q == ST_PEND && mux_attr.trans == HTRANS_SEQ) begin
            out_attr.trans = HTRANS_NONSEQ;
            out_attr.burst = HBURST_INCR;
        end else if (state_q != ST_PEND && remap_q && HSELS && HTRANSS == HTRANS_SEQ) begin
            out_attr.burst = HBURST_INCR;
        end
    end
`else
    // Held and live attributes are presented unmodified.
    always_comb begin
        out_attr = mux_attr;
    end
`endif

    // Outputs towards the master, the decoder and the arbiters.
    always_comb begin
        HADDRI      = mux_addr;
        HTRANSI     = out_attr.trans;
        HWRITEI     = out_attr.write;
        HSIZEI      = out_attr.size;
        HBURSTI     = out_attr.burst;
        HPROTI      = out_attr.prot;
        HMASTLOCKI  = out_attr.lock;
        trans_req_o = (state_q == ST_PEND) | cap;
        HREADYOUTS  = (state_q == ST_PEND) ? 1'b0 :
                      (state_q == ST_DATA) ? readyout_i : 1'b1;
        HRESPS      = (state_q == ST_DATA) ? resp_i : HRESP_OKAY;
    end

endmodule

// File: tb/tb_bm_input_stage.sv
// Bench for bm_input_stage: directed vectors with literal expectations plus
// a transaction-level model checked against the outputs on every cycle.
module tb_bm_input_stage;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsels;
    logic [31:0] haddrs;
    logic [1:0]  htranss;
    logic        hwrites;
    logic [2:0]  hsizes;
    logic [2:0]  hbursts;
    logic [3:0]  hprots;
    logic        hmastlocks;
    logic        hreadys;
    logic        hreadyouts;
    logic        hresps;
    logic [31:0] haddri;
    logic [1:0]  htransi;
    logic        hwritei;
    logic [2:0]  hsizei;
    logic [2:0]  hbursti;
    logic [3:0]  hproti;
    logic        hmastlocki;
    logic        trans_req;
    logic        addr_accept;
    logic        readyout;
    logic        resp;

    int n_vec = 0;
    int n_bad = 0;
    int waits;

    // Single master on this port: the bus-wide HREADY it sees is our ready.
    assign hreadys = hreadyouts;

    bm_input_stage #(.ADDR_W(32)) dut (
        .HCLK          (hclk),
        .HRESETn       (hresetn),
        .HSELS         (hsels),
        .HADDRS        (haddrs),
        .HTRANSS       (htranss),
        .HWRITES       (hwrites),
        .HSIZES        (hsizes),
        .HBURSTS       (hbursts),
        .HPROTS        (hprots),
        .HMASTLOCKS    (hmastlocks),
        .HREADYS       (hreadys),
        .HREADYOUTS    (hreadyouts),
        .HRESPS        (hresps),
        .HADDRI        (haddri),
        .HTRANSI       (htransi),
        .HWRITEI       (hwritei),
        .HSIZEI        (hsizei),
        .HBURSTI       (hbursti),
        .HPROTI        (hproti),
        .HMASTLOCKI    (hmastlocki),
        .trans_req_o   (trans_req),
        .addr_accept_i (addr_accept),
        .readyout_i    (readyout),
        .resp_i        (resp)
    );

    // Clock
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic sel, input logic [31:0] addr, input logic [1:0] tr,
                          input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                          input logic [3:0] pr, input logic lk);
        hsels = sel; haddrs = addr; htranss = tr; hwrites = wr;
        hsizes = sz; hbursts = bu; hprots = pr; hmastlocks = lk;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Model: at most one held transfer, a data-phase flag and a remap flag.
    bit          m_pend  = 1'b0;
    bit          m_data  = 1'b0;
    bit          m_remap = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [1:0]  m_trans = '0;
    logic        m_write = '0;
    logic [2:0]  m_size  = '0;
    logic [2:0]  m_burst = '0;
    logic [3:0]  m_prot  = '0;
    logic        m_lock  = '0;

    always @(negedge hresetn) begin
        m_pend = 1'b0; m_data = 1'b0; m_remap = 1'b0;
        m_addr = '0; m_trans = '0; m_write = '0; m_size = '0;
        m_burst = '0; m_prot = '0; m_lock = '0;
    end

    // Compare against the model mid-cycle, then advance it by one clock.
    always @(negedge hclk) begin : cmp
        logic       e_rdy, e_cap, e_resp, e_req;
        logic [1:0] e_trans;
        logic [2:0] e_burst;
        if (hresetn) begin
            e_rdy   = m_pend ? 1'b0 : (m_data ? readyout : 1'b1);
            e_cap   = hsels && htranss[1] && e_rdy;
            e_resp  = m_data ? resp : 1'b0;
            e_req   = m_pend || e_cap;
            e_trans = m_pend ? m_trans : htranss;
            e_burst = m_pend ? m_burst : hbursts;
`ifdef BM_INPUT_SEQ_REMAP_EN
            if (m_pend && m_trans == T_SEQ) begin
                e_trans = T_NONSEQ;
                e_burst = B_INCR;
            end else if (!m_pend && m_remap && hsels && htranss == T_SEQ) begin
                e_burst = B_INCR;
            end
`endif
            chk("m_hreadyouts", hreadyouts, e_rdy);
            chk("m_hresps", hresps, e_resp);
            chk("m_trans_req", trans_req, e_req);
            chk("m_haddri", haddri, m_pend ? m_addr : haddrs);
            chk("m_htransi", htransi, e_trans);
            chk("m_hwritei", hwritei, m_pend ? m_write : hwrites);
            chk("m_hsizei", hsizei, m_pend ? m_size : hsizes);
            chk("m_hbursti", hbursti, e_burst);
            chk("m_hproti", hproti, m_pend ? m_prot : hprots);
            chk("m_hmastlocki", hmastlocki, m_pend ? m_lock : hmastlocks);
`ifdef BM_INPUT_SEQ_REMAP_EN
            if (m_remap && (!hsels || htranss == T_IDLE || htranss == T_NONSEQ)) m_remap = 1'b0;
            if (m_pend && addr_accept && m_trans == T_SEQ) m_remap = 1'b1;
`endif
            if (m_pend) begin
                if (addr_accept) begin
                    m_pend = 1'b0;
                    m_data = 1'b1;
                end
            end else if (e_rdy) begin
                if (e_cap && addr_accept) begin
                    m_data = 1'b1;
                end else if (e_cap) begin
                    m_pend = 1'b1; m_data = 1'b0;
                    m_addr = haddrs; m_trans = htranss; m_write = hwrites;
                    m_size = hsizes; m_burst = hbursts; m_prot = hprots; m_lock = hmastlocks;
                end else begin
                    m_data = 1'b0;
                end
            end
        end
    end

    initial begin
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        addr_accept = 1'b0; readyout = 1'b1; resp = 1'b0;
        hresetn = 1'b0;

        // Reset state
        repeat (2) @(posedge hclk);
        #1;
        htranss = T_BUSY;
        #1;
        chk("rst_hreadyouts", hreadyouts, 1'b1);
        chk("rst_hresps", hresps, 1'b0);
        chk("rst_trans_req", trans_req, 1'b0);
        chk("rst_htransi_live", htransi, 2'b01);
        hresetn = 1'b1;
        htranss = T_IDLE;
        tick();

        // Immediate grant
        set_in(1'b1, 32'h1000, T_NONSEQ, 1'b0, 3'd2, B_SINGLE, 4'h3, 1'b0);
        addr_accept = 1'b1; readyout = 1'b1;
        #1;
        chk("imm_haddri", haddri, 32'h1000);
        chk("imm_req", trans_req, 1'b1);
        chk("imm_ready", hreadyouts, 1'b1);
        tick();
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        addr_accept = 1'b0; readyout = 1'b0;
        #1;
        chk("imm_data_wait", hreadyouts, 1'b0);
        tick();
        readyout = 1'b1;
        #1;
        chk("imm_data_done", hreadyouts, 1'b1);
        tick();

        // Delayed grant: three PEND cycles
        set_in(1'b1, 32'h2004, T_NONSEQ, 1'b1, 3'd2, B_SINGLE, 4'h3, 1'b0);
        addr_accept = 1'b0;
        #1;
        chk("dly_req_cap", trans_req, 1'b1);
        tick();
        waits = 0;
        for (int i = 0; i < 3; i++) begin
            set_in(i[0], 32'h5555_0000 + i, i[0] ? T_NONSEQ : T_IDLE, 1'b0, 3'd0, B_INCR4, 4'h0, 1'b1);
            addr_accept = (i == 2);
            #1;
            if (hreadyouts == 1'b0) waits++;
            chk("dly_haddri_held", haddri, 32'h2004);
            chk("dly_hwritei_held", hwritei, 1'b1);
            chk("dly_req_pend", trans_req, 1'b1);
            tick();
        end
        chk("dly_wait_states", waits, 3);
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        addr_accept = 1'b0; readyout = 1'b1;
        #1;
        chk("dly_data_ready", hreadyouts, 1'b1);
        tick();

        // Back-to-back capture out of DATA
        set_in(1'b1, 32'h4000, T_NONSEQ, 1'b0, 3'd2, B_INCR, 4'h3, 1'b0);
        addr_accept = 1'b1;
        #1;
        tick();
        set_in(1'b1, 32'h4010, T_NONSEQ, 1'b1, 3'd1, B_SINGLE, 4'h2, 1'b1);
        addr_accept = 1'b0; readyout = 1'b1; resp = 1'b0;
        #1;
        chk("b2b_hresps", hresps, 1'b0);
        chk("b2b_ready", hreadyouts, 1'b1);
        chk("b2b_req", trans_req, 1'b1);
        tick();
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        #1;
        chk("b2b_hold_addr", haddri, 32'h4010);
        chk("b2b_hold_lock", hmastlocki, 1'b1);
        chk("b2b_hold_size", hsizei, 3'd1);
        chk("b2b_stall", hreadyouts, 1'b0);
        tick();
        addr_accept = 1'b1;
        #1;
        tick();
        addr_accept = 1'b0; readyout = 1'b1;
        #1;
        tick();

        // Two-cycle ERROR response
        set_in(1'b1, 32'h6000, T_NONSEQ, 1'b0, 3'd2, B_SINGLE, 4'h3, 1'b0);
        addr_accept = 1'b1;
        #1;
        tick();
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        addr_accept = 1'b0; readyout = 1'b0; resp = 1'b1;
        #1;
        chk("err1_hresps", hresps, 1'b1);
        chk("err1_ready", hreadyouts, 1'b0);
        tick();
        readyout = 1'b1;
        #1;
        chk("err2_hresps", hresps, 1'b1);
        chk("err2_ready", hreadyouts, 1'b1);
        tick();
        readyout = 1'b0; addr_accept = 1'b1;
        #1;
        chk("idle_ready", hreadyouts, 1'b1);
        chk("idle_hresps", hresps, 1'b0);
        chk("idle_req", trans_req, 1'b0);
        tick();
        addr_accept = 1'b0; resp = 1'b0;
        #1;
        chk("idle_accept_ignored", hreadyouts, 1'b1);
        tick();

        // Held SEQ with INCR4
        set_in(1'b1, 32'h3008, T_SEQ, 1'b0, 3'd2, B_INCR4, 4'h3, 1'b0);
        addr_accept = 1'b0; readyout = 1'b1;
        #1;
        tick();
        #1;
`ifdef BM_INPUT_SEQ_REMAP_EN
        chk("remap_pend_trans", htransi, T_NONSEQ);
        chk("remap_pend_burst", hbursti, B_INCR);
`else
        chk("remap_pend_trans", htransi, T_SEQ);
        chk("remap_pend_burst", hbursti, B_INCR4);
`endif
        chk("remap_pend_addr", haddri, 32'h3008);
        tick();
        addr_accept = 1'b1;
        #1;
        tick();
        set_in(1'b1, 32'h300C, T_SEQ, 1'b0, 3'd2, B_INCR4, 4'h3, 1'b0);
        addr_accept = 1'b1; readyout = 1'b1;
        #1;
`ifdef BM_INPUT_SEQ_REMAP_EN
        chk("remap_live_burst", hbursti, B_INCR);
`else
        chk("remap_live_burst", hbursti, B_INCR4);
`endif
        chk("remap_live_trans", htransi, T_SEQ);
        tick();
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        addr_accept = 1'b0; readyout = 1'b1;
        #1;
        tick();

        // Reset while PEND
        set_in(1'b1, 32'h7000, T_NONSEQ, 1'b1, 3'd2, B_SINGLE, 4'h3, 1'b0);
        addr_accept = 1'b0;
        #1;
        tick();
        set_in(1'b0, 32'h0, T_IDLE, 1'b0, 3'd0, B_SINGLE, 4'h0, 1'b0);
        #1;
        chk("rp_stall", hreadyouts, 1'b0);
        chk("rp_req", trans_req, 1'b1);
        hresetn = 1'b0;
        #1;
        chk("rp_req_async", trans_req, 1'b0);
        chk("rp_ready_async", hreadyouts, 1'b1);
        tick();
        tick();
        hresetn = 1'b1;
        readyout = 1'b0;
        #1;
        tick();
        #1;
        chk("rp_after_ready", hreadyouts, 1'b1);
        chk("rp_after_req", trans_req, 1'b0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
